// File: rtl/pipereg_hs.sv
// pipereg_hs: DEPTH-stage valid/ready pipeline register. Each stage has a main and a skid entry, so in_ready is registered.
// Optional occupancy counter/port is enabled by defining PIPEREG_OCC_EN.
module pipereg_hs #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1
`ifdef PIPEREG_OCC_EN
    ,
    parameter int OCC_W = $clog2(2 * DEPTH + 1)
`endif
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPEREG_OCC_EN
    ,
    output logic [OCC_W-1:0] occupancy
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state_e;

    logic [DEPTH-1:0] stage_valid;
    logic [DEPTH-1:0] stage_ready;
    logic [DEPTH-1:0] up_valid;
    logic [DEPTH-1:0] dn_ready;
    logic [DEPTH-1:0] push;
    logic [DEPTH-1:0] pop;
    logic [WIDTH-1:0] up_data    [DEPTH];
    logic [WIDTH-1:0] stage_main [DEPTH];

    genvar gi;
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
        stage_state_e     state_q;
        logic [WIDTH-1:0] main_q;
        logic [WIDTH-1:0] skid_q;
        logic             ready_q;

        if (gi == 0) begin : g_head
            assign up_valid[gi] = in_valid;
            assign up_data[gi]  = in_data;
        end else begin : g_link
            assign up_valid[gi] = stage_valid[gi-1];
            assign up_data[gi]  = stage_main[gi-1];
        end

        if (gi == DEPTH - 1) begin : g_tail
            assign dn_ready[gi] = out_ready;
        end else begin : g_mid
            assign dn_ready[gi] = stage_ready[gi+1];
        end

        assign stage_valid[gi] = (state_q != ST_EMPTY);
        assign stage_ready[gi] = ready_q;
        assign stage_main[gi]  = main_q;
        assign push[gi]        = up_valid[gi] & ready_q;
        assign pop[gi]         = stage_valid[gi] & dn_ready[gi];

        // ready_q tracks "next state is not SKID" so the producer sees a flop, never a comb path.
        always_ff @(posedge clk) begin
            if (clr) begin
                state_q <= ST_EMPTY;
                main_q  <= '0;
                skid_q  <= '0;
                ready_q <= 1'b1;
            end else if (flush) begin
                state_q <= ST_EMPTY;
                ready_q <= 1'b1;
            end else begin
                unique case (state_q)
                    ST_EMPTY: begin
                        if (push[gi]) begin
                            state_q <= ST_FULL;
                            main_q  <= up_data[gi];
                        end
                    end
                    ST_FULL: begin
                        if (push[gi] && pop[gi]) begin
                            main_q <= up_data[gi];
                        end else if (push[gi]) begin
                            state_q <= ST_SKID;
                            skid_q  <= up_data[gi];
                            ready_q <= 1'b0;
                        end else if (pop[gi]) begin
                            state_q <= ST_EMPTY;
                        end
                    end
                    ST_SKID: begin
                        if (pop[gi]) begin
                            state_q <= ST_FULL;
                            main_q  <= skid_q;
                            ready_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_EMPTY;
                        ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign in_ready  = stage_ready[0];
    assign out_valid = stage_valid[DEPTH-1];
    assign out_data  = stage_main[DEPTH-1];

`ifdef PIPEREG_OCC_EN
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic             in_fire;
    logic             out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        occ_d = occ_q;
        if (in_fire && !out_fire) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (out_fire && !in_fire) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr || flush) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    // The stage chain can never hold more than 2*DEPTH entries.
    always_ff @(posedge clk) begin
        if (!clr) begin
            assert (occ_q <= OCC_W'(2 * DEPTH));
        end
    end

    assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_pipereg_hs.sv
// Bench for pipereg_hs: eight instances (DEPTH 1..8) share stimulus; a per-instance FIFO scoreboard
// plus invariants is checked every cycle, and directed cases pin exact latency, capacity and clr/flush.
module tb_pipereg_hs;

    localparam int N_INST = 8;
    localparam int W      = 32;

    logic             clk = 1'b0;
    logic             clr;
    logic             flush;
    logic             in_valid;
    logic             out_ready;
    logic [W-1:0]     in_data;
    logic [N_INST-1:0] in_ready_w;
    logic [N_INST-1:0] out_valid_w;
    logic [W-1:0]     out_data_w [N_INST];
`ifdef PIPEREG_OCC_EN
    logic [4:0]       occ_w [N_INST];
`endif

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N_INST; gi++) begin : g_dut
        logic [W-1:0] od;
`ifdef PIPEREG_OCC_EN
        localparam int OW = $clog2(2 * (gi + 1) + 1);
        logic [OW-1:0] occ_l;
        assign occ_w[gi] = 5'(occ_l);
`endif
        pipereg_hs #(.WIDTH(W), .DEPTH(gi + 1)) u_dut (
            .clk       (clk),
            .clr       (clr),
            .flush     (flush),
            .in_valid  (in_valid),
            .in_ready  (in_ready_w[gi]),
            .in_data   (in_data),
            .out_valid (out_valid_w[gi]),
            .out_ready (out_ready),
            .out_data  (od)
`ifdef PIPEREG_OCC_EN
            ,
            .occupancy (occ_l)
`endif
        );
        assign out_data_w[gi] = od;
    end

    int n_vec = 0;
    int n_err = 0;
    logic mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: what has been accepted but not yet delivered, per instance.
    logic [W-1:0] sb_mem [N_INST][64];
    int           sb_head [N_INST];
    int           sb_cnt  [N_INST];
    int           stall   [N_INST];
    int           m_d;
    logic         m_fin;
    logic         m_fout;

    initial begin
        for (int i = 0; i < N_INST; i++) begin
            sb_head[i] = 0;
            sb_cnt[i]  = 0;
            stall[i]   = 0;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < N_INST; i++) begin
                m_d    = i + 1;
                m_fin  = in_valid & in_ready_w[i] & !clr & !flush;
                m_fout = out_valid_w[i] & out_ready & !clr;
                if (out_valid_w[i])
                    check($sformatf("d%0d_valid_nonempty", m_d), 32'(sb_cnt[i] > 0), 32'd1);
                if (m_fout && sb_cnt[i] > 0)
                    check($sformatf("d%0d_out_data", m_d), out_data_w[i], sb_mem[i][sb_head[i]]);
                if (sb_cnt[i] == 2 * m_d)
                    check($sformatf("d%0d_full_ready", m_d), 32'(in_ready_w[i]), 32'd0);
                if (!in_ready_w[i])
                    check($sformatf("d%0d_busy_holds2", m_d), 32'(sb_cnt[i] >= 2), 32'd1);
`ifdef PIPEREG_OCC_EN
                check($sformatf("d%0d_occupancy", m_d), 32'(occ_w[i]), 32'(sb_cnt[i]));
`endif
                if (out_ready && !clr && !flush && sb_cnt[i] > 0 && !out_valid_w[i])
                    stall[i]++;
                else
                    stall[i] = 0;
                check($sformatf("d%0d_no_stall", m_d), 32'(stall[i] <= m_d + 2), 32'd1);

                if (clr || flush) begin
                    sb_cnt[i]  = 0;
                    sb_head[i] = 0;
                end else begin
                    if (m_fout && sb_cnt[i] > 0) begin
                        sb_head[i] = (sb_head[i] + 1) % 64;
                        sb_cnt[i]--;
                    end
                    if (m_fin) begin
                        sb_mem[i][(sb_head[i] + sb_cnt[i]) % 64] = in_data;
                        sb_cnt[i]++;
                        check($sformatf("d%0d_capacity", m_d), 32'(sb_cnt[i] <= 2 * m_d), 32'd1);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_pulse();
        clr = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        step();
        clr = 1'b0;
    endtask

    int   acc;
    logic done;
    logic [31:0] exp_rdy [5] = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd1};

    initial begin
        clr = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        step();
        step();
        clr = 1'b0;
        mon_en = 1'b1;

        // Idle after reset, DEPTH=1 and DEPTH=4
        @(negedge clk);
        check("t1_d1_in_ready",  32'(in_ready_w[0]),  32'd1);
        check("t1_d1_out_valid", 32'(out_valid_w[0]), 32'd0);
        check("t1_d1_out_data",  out_data_w[0],        32'd0);
        check("t1_d4_in_ready",  32'(in_ready_w[3]),  32'd1);
        check("t1_d4_out_valid", 32'(out_valid_w[3]), 32'd0);
        check("t1_d4_out_data",  out_data_w[3],        32'd0);
        step();

        // DEPTH=3 back-to-back stream: first output after 3 edges, then 1/cycle
        for (int c = 0; c < 38; c++) begin
            in_valid = (c < 32); in_data = 32'(c + 1); out_ready = 1'b1;
            @(negedge clk);
            check("t2_d3_in_ready", 32'(in_ready_w[2]), 32'd1);
            if (c >= 3 && c <= 34) begin
                check("t2_d3_out_valid", 32'(out_valid_w[2]), 32'd1);
                check("t2_d3_out_data",  out_data_w[2],        32'(c - 2));
            end else begin
                check("t2_d3_out_idle", 32'(out_valid_w[2]), 32'd0);
            end
            step();
        end

        // DEPTH=2 capacity under back-pressure, then drain
        clr_pulse();
        acc = 0; done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            in_valid = 1'b1; in_data = 32'h100 + 32'(acc); out_ready = 1'b0;
            @(negedge clk);
            if (in_ready_w[1]) acc++; else done = 1'b1;
            step();
        end
        check("t3_d2_accepted", 32'(acc), 32'd4);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
`ifdef PIPEREG_OCC_EN
            if (j == 0) check("t3_d2_occ_full", 32'(occ_w[1]), 32'd4);
`endif
            check("t3_d2_in_ready", 32'(in_ready_w[1]), exp_rdy[j]);
            if (j < 4) begin
                check("t3_d2_out_valid", 32'(out_valid_w[1]), 32'd1);
                check("t3_d2_out_data",  out_data_w[1],        32'h100 + 32'(j));
            end else begin
                check("t3_d2_drained", 32'(out_valid_w[1]), 32'd0);
            end
            step();
        end

        // Flush a full pipe while an input is offered
        clr_pulse();
        for (int c = 0; c < 24; c++) begin
            in_valid = 1'b1; in_data = 32'h200 + 32'(c); out_ready = 1'b0;
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N_INST; i++)
            check($sformatf("t5_d%0d_full", i + 1), 32'(in_ready_w[i]), 32'd0);
        step();
        flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEADBEEF;
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N_INST; i++) begin
            check($sformatf("t5_d%0d_valid", i + 1), 32'(out_valid_w[i]), 32'd0);
            check($sformatf("t5_d%0d_ready", i + 1), 32'(in_ready_w[i]),  32'd1);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            @(negedge clk);
            check("t5_d8_no_ghost", 32'(out_valid_w[7]), 32'd0);
        end
        step();

        // clr and flush together mid-stream, then an 0xA5 stream
        clr_pulse();
        for (int c = 0; c < 12; c++) begin
            in_valid = 1'b1; in_data = 32'h300 + 32'(c); out_ready = c[0];
            step();
        end
        clr = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 32'h3FF; out_ready = 1'b1;
        step();
        clr = 1'b0; flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N_INST; i++) begin
            check($sformatf("t6_d%0d_data0", i + 1), out_data_w[i],        32'd0);
            check($sformatf("t6_d%0d_valid", i + 1), 32'(out_valid_w[i]), 32'd0);
            check($sformatf("t6_d%0d_ready", i + 1), 32'(in_ready_w[i]),  32'd1);
        end
        step();
        for (int c = 0; c < 24; c++) begin
            in_valid = (c < 16); in_data = 32'hA5 | (32'(c) << 8); out_ready = 1'b1;
            @(negedge clk);
            if (c >= 1 && c <= 16) begin
                check("t6_d1_out_valid", 32'(out_valid_w[0]), 32'd1);
                check("t6_d1_out_data",  out_data_w[0],        32'hA5 | (32'(c - 1) << 8));
            end else begin
                check("t6_d1_out_idle", 32'(out_valid_w[0]), 32'd0);
            end
            step();
        end

        // Random traffic against the scoreboard, then drain
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 40; c++) step();
        for (int i = 0; i < N_INST; i++) begin
            check($sformatf("t4_d%0d_drained", i + 1), 32'(sb_cnt[i]),      32'd0);
            check($sformatf("t4_d%0d_idle", i + 1),    32'(out_valid_w[i]), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
